// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RV32 decode-control stage.
//   - RV32 major opcodes used by the decoder
//   - ALU operation, access-width and writeback-select encodings
//   - decoded-control struct carried from ctrl_decode into the stage registers
//   - FSM state type and a small helper for sizing the multicycle counter
package riscv_ctrl_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_I1  = 7'b0000011;  // loads
  localparam logic [6:0] OP_I2  = 7'b0010011;  // immediate ALU
  localparam logic [6:0] OP_S   = 7'b0100011;  // stores
  localparam logic [6:0] OP_R   = 7'b0110011;  // register ALU / M-extension
  localparam logic [6:0] OP_B   = 7'b1100011;  // branches
  localparam logic [6:0] OP_J   = 7'b1101111;  // JAL
  localparam logic [6:0] OP_JR  = 7'b1100111;  // JALR
  localparam logic [6:0] OP_U   = 7'b0110111;  // LUI
  localparam logic [6:0] OP_UPC = 7'b0010111;  // AUIPC

  // func7 values that select an operation variant
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;  // SUB / SRA / SRAI
  localparam logic [6:0] F7_MD   = 7'b0000001;  // MUL/DIV/REM family

  // ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SLL = 4'b1010;
  localparam logic [3:0] ALU_SRA = 4'b1100;
  localparam logic [3:0] ALU_LUI = 4'b1101;

  // Memory access width
  localparam logic [1:0] WHB_B = 2'b00;
  localparam logic [1:0] WHB_H = 2'b01;
  localparam logic [1:0] WHB_W = 2'b10;

  // Writeback select
  localparam logic [1:0] WOS_CMP = 2'b00;
  localparam logic [1:0] WOS_ALU = 2'b01;
  localparam logic [1:0] WOS_PC4 = 2'b10;

  // Decoded control fields; illegal/md_en travel beside this struct.
  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic [1:0] whb;
    logic       su;
    logic [1:0] wos;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       jalr;
    logic [2:0] md_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_MD_WAIT = 2'b01,
    ST_FULL    = 2'b10
  } state_e;

  function automatic int max_lat(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational RV32I(+M) control decoder.
// Ports:
//   i_instr   : 32-bit instruction word
//   o_ctrl    : decoded control fields (all zero for an illegal encoding)
//   o_illegal : encoding not recognised (or M op with ENABLE_M = 0)
//   o_md_en   : legal M-extension operation; o_ctrl.md_op holds its func3
// Fields not meaningful for an instruction class are left at zero
// (e.g. whb/su on ALU ops, wos on stores and branches).
module ctrl_decode
  import riscv_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [31:0] i_instr,
  output ctrl_t       o_ctrl,
  output logic        o_illegal,
  output logic        o_md_en
);

  logic [6:0] w_op;
  logic [6:0] w_f7;
  logic [2:0] w_f3;
  ctrl_t      w_ctrl;
  logic       w_bad;
  logic       w_md;

  assign w_op = i_instr[6:0];
  assign w_f3 = i_instr[14:12];
  assign w_f7 = i_instr[31:25];

  always_comb begin
    w_ctrl = CTRL_NONE;
    w_bad  = 1'b0;
    w_md   = 1'b0;
    case (w_op)
      OP_R: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.wos       = WOS_ALU;
        case (w_f7)
          F7_BASE: begin
            case (w_f3)
              3'b000: w_ctrl.alu_ctrl = ALU_ADD;
              3'b001: w_ctrl.alu_ctrl = ALU_SLL;
              3'b010: begin  // SLT: signed compare via subtract
                w_ctrl.alu_ctrl = ALU_SUB;
                w_ctrl.su       = 1'b1;
                w_ctrl.wos      = WOS_CMP;
              end
              3'b011: begin  // SLTU
                w_ctrl.alu_ctrl = ALU_SUB;
                w_ctrl.wos      = WOS_CMP;
              end
              3'b100: w_ctrl.alu_ctrl = ALU_XOR;
              3'b101: w_ctrl.alu_ctrl = ALU_SRL;
              3'b110: w_ctrl.alu_ctrl = ALU_OR;
              3'b111: w_ctrl.alu_ctrl = ALU_AND;
            endcase
          end
          F7_ALT: begin
            case (w_f3)
              3'b000:  w_ctrl.alu_ctrl = ALU_SUB;
              3'b101:  w_ctrl.alu_ctrl = ALU_SRA;
              default: w_bad = 1'b1;
            endcase
          end
          F7_MD: begin
            if (ENABLE_M) begin
              w_md         = 1'b1;
              w_ctrl.md_op = w_f3;
            end else begin
              w_bad = 1'b1;
            end
          end
          default: w_bad = 1'b1;
        endcase
      end
      OP_I2: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.wos       = WOS_ALU;
        case (w_f3)
          3'b000: w_ctrl.alu_ctrl = ALU_ADD;
          3'b010: begin  // SLTI
            w_ctrl.alu_ctrl = ALU_SUB;
            w_ctrl.su       = 1'b1;
            w_ctrl.wos      = WOS_CMP;
          end
          3'b011: begin  // SLTIU
            w_ctrl.alu_ctrl = ALU_SUB;
            w_ctrl.wos      = WOS_CMP;
          end
          3'b100: w_ctrl.alu_ctrl = ALU_XOR;
          3'b110: w_ctrl.alu_ctrl = ALU_OR;
          3'b111: w_ctrl.alu_ctrl = ALU_AND;
          3'b001: begin  // SLLI: shamt is 5 bits, upper bits must be zero
            if (w_f7 == F7_BASE) w_ctrl.alu_ctrl = ALU_SLL;
            else                 w_bad = 1'b1;
          end
          3'b101: begin  // SRLI / SRAI
            if (w_f7 == F7_BASE)     w_ctrl.alu_ctrl = ALU_SRL;
            else if (w_f7 == F7_ALT) w_ctrl.alu_ctrl = ALU_SRA;
            else                     w_bad = 1'b1;
          end
        endcase
      end
      OP_I1: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.wos       = WOS_ALU;
        case (w_f3)
          3'b000: begin w_ctrl.whb = WHB_B; w_ctrl.su = 1'b1; end
          3'b001: begin w_ctrl.whb = WHB_H; w_ctrl.su = 1'b1; end
          3'b010: begin w_ctrl.whb = WHB_W; w_ctrl.su = 1'b1; end
          3'b100: w_ctrl.whb = WHB_B;
          3'b101: w_ctrl.whb = WHB_H;
          default: w_bad = 1'b1;
        endcase
      end
      OP_S: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        case (w_f3)
          3'b000:  w_ctrl.whb = WHB_B;
          3'b001:  w_ctrl.whb = WHB_H;
          3'b010:  w_ctrl.whb = WHB_W;
          default: w_bad = 1'b1;
        endcase
      end
      OP_B: begin
        w_ctrl.branch   = 1'b1;
        w_ctrl.alu_ctrl = ALU_SUB;
        case (w_f3)
          3'b000, 3'b001, 3'b100, 3'b101: w_ctrl.su = 1'b1;
          3'b110, 3'b111:                 w_ctrl.su = 1'b0;
          default:                        w_bad = 1'b1;
        endcase
      end
      OP_J: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.branch    = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.wos       = WOS_PC4;
      end
      OP_JR: begin
        if (w_f3 == 3'b000) begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.branch    = 1'b1;
          w_ctrl.jalr      = 1'b1;
          w_ctrl.alu_src   = 1'b1;
          w_ctrl.wos       = WOS_PC4;
        end else begin
          w_bad = 1'b1;
        end
      end
      OP_U: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_ctrl  = ALU_LUI;
        w_ctrl.wos       = WOS_ALU;
      end
      OP_UPC: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_ctrl  = ALU_ADD;
        w_ctrl.wos       = WOS_ALU;
      end
      default: w_bad = 1'b1;
    endcase
  end

  // An illegal encoding must not leak partially decoded fields downstream.
  assign o_ctrl    = w_bad ? CTRL_NONE : w_ctrl;
  assign o_illegal = w_bad;
  assign o_md_en   = w_md & ~w_bad;

endmodule

// File: rtl/id_ctrl_stage.sv
// Registered instruction-decode control stage (IF/ID -> EX) with a
// valid/ready handshake on both sides and a multicycle hold for M ops.
// Parameters: XLEN (PC width), ENABLE_M, MUL_LATENCY, DIV_LATENCY (both >= 1).
// Ports:
//   clk, rst_n (synchronous, active-low), flush (kills held/in-progress op)
//   in_valid/in_ready, in_instr, in_pc       : upstream side
//   out_valid/out_ready, out_instr, out_pc   : downstream side
//   alu_ctrl, whb, su, wos, reg_write, mem_read, mem_write, alu_src,
//   branch, jalr, md_en, md_op, illegal      : registered decode
//   md_busy                                  : multicycle countdown active
module id_ctrl_stage
  import riscv_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit ENABLE_M    = 1'b1,
  parameter int MUL_LATENCY = 2,
  parameter int DIV_LATENCY = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      alu_ctrl,
  output logic [1:0]      whb,
  output logic            su,
  output logic [1:0]      wos,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            alu_src,
  output logic            branch,
  output logic            jalr,
  output logic            md_en,
  output logic [2:0]      md_op,
  output logic            illegal,
  output logic            md_busy
);

  localparam int MAX_LAT = max_lat(MUL_LATENCY, DIV_LATENCY);
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  // Counter is loaded with L-1: the accept cycle itself counts as one.
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LATENCY - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_lat_cnt;
  logic              w_accept;
  logic              w_md_multi;

  ctrl_t             w_dec_ctrl;
  logic              w_dec_illegal;
  logic              w_dec_md_en;

  ctrl_t             r_ctrl;
  logic              r_illegal;
  logic              r_md_en;
  logic [31:0]       r_instr;
  logic [XLEN-1:0]   r_pc;

  ctrl_decode #(
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .i_instr   (in_instr),
    .o_ctrl    (w_dec_ctrl),
    .o_illegal (w_dec_illegal),
    .o_md_en   (w_dec_md_en)
  );

  assign w_accept   = in_valid & in_ready;
  // func3[2] separates DIV/DIVU/REM/REMU from the MUL family.
  assign w_lat_cnt  = w_dec_ctrl.md_op[2] ? DIV_CNT : MUL_CNT;
  assign w_md_multi = w_dec_md_en & (w_lat_cnt != '0);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state. An accept is only possible from EMPTY or FULL (in_ready),
  // so it is handled once ahead of the per-state behaviour.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_cnt_nxt   = '0;
    end else if (w_accept) begin
      if (w_md_multi) begin
        w_state_nxt = ST_MD_WAIT;
        w_cnt_nxt   = w_lat_cnt;
      end else begin
        w_state_nxt = ST_FULL;
        w_cnt_nxt   = '0;
      end
    end else begin
      case (r_state)
        ST_MD_WAIT: begin
          // Saturating countdown; the last decrement releases the result.
          if (r_cnt > CNT_W'(1)) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_FULL;
          end
        end
        ST_FULL: begin
          if (out_ready) w_state_nxt = ST_EMPTY;
        end
        ST_EMPTY: w_state_nxt = ST_EMPTY;
        default: begin
          w_state_nxt = ST_EMPTY;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs of the FSM
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    md_busy   = 1'b0;
    case (r_state)
      ST_EMPTY:   in_ready = 1'b1;
      ST_FULL: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      ST_MD_WAIT: md_busy = 1'b1;
      default:    in_ready = 1'b0;
    endcase
    in_ready = in_ready & rst_n & ~flush;
  end

  // Output registers: loaded only on accept, so they hold under back-pressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctrl    <= CTRL_NONE;
      r_illegal <= 1'b0;
      r_md_en   <= 1'b0;
      r_instr   <= '0;
      r_pc      <= '0;
    end else if (w_accept) begin
      r_ctrl    <= w_dec_ctrl;
      r_illegal <= w_dec_illegal;
      r_md_en   <= w_dec_md_en;
      r_instr   <= in_instr;
      r_pc      <= in_pc;
    end
  end

  assign out_instr = r_instr;
  assign out_pc    = r_pc;
  assign alu_ctrl  = r_ctrl.alu_ctrl;
  assign whb       = r_ctrl.whb;
  assign su        = r_ctrl.su;
  assign wos       = r_ctrl.wos;
  assign reg_write = r_ctrl.reg_write;
  assign mem_read  = r_ctrl.mem_read;
  assign mem_write = r_ctrl.mem_write;
  assign alu_src   = r_ctrl.alu_src;
  assign branch    = r_ctrl.branch;
  assign jalr      = r_ctrl.jalr;
  assign md_op     = r_ctrl.md_op;
  assign md_en     = r_md_en;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_id_ctrl_stage.sv
module tb_id_ctrl_stage;

  localparam int MUL_L = 2;
  localparam int DIV_L = 8;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SLTU = 32'h0020B2B3;
  localparam logic [31:0] I_LBU  = 32'h0000C203;
  localparam logic [31:0] I_DIV  = 32'h0220C1B3;
  localparam logic [31:0] I_ONES = 32'hFFFFFFFF;

  localparam logic [31:0] MR  = 32'hFE00707F;  // opcode + func3 + func7
  localparam logic [31:0] MF3 = 32'h0000707F;  // opcode + func3
  localparam logic [31:0] MOP = 32'h0000007F;  // opcode only

  localparam logic [5:0] RW = 6'b100000, MRD = 6'b010000, MW = 6'b001000;
  localparam logic [5:0] AS = 6'b000100, BR = 6'b000010, JR = 6'b000001;

  logic clk = 1'b0;
  logic rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0;

  logic in_ready, out_valid, su, reg_write, mem_read, mem_write, alu_src;
  logic branch, jalr, md_en, illegal, md_busy;
  logic [31:0] out_instr, out_pc;
  logic [3:0] alu_ctrl;
  logic [1:0] whb, wos;
  logic [2:0] md_op;

  logic n_in_ready, n_out_valid, n_su, n_reg_write, n_mem_read, n_mem_write, n_alu_src;
  logic n_branch, n_jalr, n_md_en, n_illegal, n_md_busy;
  logic [31:0] n_out_instr, n_out_pc;
  logic [3:0] n_alu_ctrl;
  logic [1:0] n_whb, n_wos;
  logic [2:0] n_md_op;

  // Observed control bundle: {illegal, alu, whb, su, wos, rw,mr,mw,as,br,jr, md_en, md_op}
  logic [19:0] obs, n_obs;
  assign obs   = {illegal, alu_ctrl, whb, su, wos, reg_write, mem_read, mem_write,
                  alu_src, branch, jalr, md_en, md_op};
  assign n_obs = {n_illegal, n_alu_ctrl, n_whb, n_su, n_wos, n_reg_write, n_mem_read,
                  n_mem_write, n_alu_src, n_branch, n_jalr, n_md_en, n_md_op};

  id_ctrl_stage #(.XLEN(32), .ENABLE_M(1'b1), .MUL_LATENCY(MUL_L), .DIV_LATENCY(DIV_L)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .alu_ctrl(alu_ctrl), .whb(whb), .su(su),
    .wos(wos), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src(alu_src), .branch(branch), .jalr(jalr), .md_en(md_en), .md_op(md_op),
    .illegal(illegal), .md_busy(md_busy));

  id_ctrl_stage #(.XLEN(32), .ENABLE_M(1'b0), .MUL_LATENCY(MUL_L), .DIV_LATENCY(DIV_L)) dut_nm (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(n_out_valid), .out_ready(out_ready),
    .out_instr(n_out_instr), .out_pc(n_out_pc), .alu_ctrl(n_alu_ctrl), .whb(n_whb), .su(n_su),
    .wos(n_wos), .reg_write(n_reg_write), .mem_read(n_mem_read), .mem_write(n_mem_write),
    .alu_src(n_alu_src), .branch(n_branch), .jalr(n_jalr), .md_en(n_md_en), .md_op(n_md_op),
    .illegal(n_illegal), .md_busy(n_md_busy));

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_total++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // ---------------- reference model: table of legal encodings ----------------
  logic [31:0] t_mask[$];
  logic [31:0] t_match[$];
  logic [19:0] t_exp[$];

  function automatic logic [19:0] mk(input logic [3:0] alu, input logic [1:0] w,
                                     input logic s, input logic [1:0] wb,
                                     input logic [5:0] fl, input logic md,
                                     input logic [2:0] mop);
    return {1'b0, alu, w, s, wb, fl, md, mop};
  endfunction

  task automatic add(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] mask, input logic [19:0] e);
    t_mask.push_back(mask);
    t_match.push_back({f7, 10'b0, f3, 5'b0, op} & mask);
    t_exp.push_back(e);
  endtask

  task automatic build_table();
    // register ALU
    add(7'h33, 3'd0, 7'h00, MR, mk(4'h0, 2'd0, 1'b0, 2'd1, RW, 1'b0, 3'd0));
    add(7'h33, 3'd0, 7'h20, MR, mk(4'h1, 2'd0, 1'b0, 2'd1, RW, 1'b0, 3'd0));
    add(7'h33, 3'd1, 7'h00, MR, mk(4'hA, 2'd0, 1'b0, 2'd1, RW, 1'b0, 3'd0));
    add(7'h33, 3'd2, 7'h00, MR, mk(4'h1, 2'd0, 1'b1, 2'd0, RW, 1'b0, 3'd0));
    add(7'h33, 3'd3, 7'h00, MR, mk(4'h1, 2'd0, 1'b0, 2'd0, RW, 1'b0, 3'd0));
    add(7'h33, 3'd4, 7'h00, MR, mk(4'h8, 2'd0, 1'b0, 2'd1, RW, 1'b0, 3'd0));
    add(7'h33, 3'd5, 7'h00, MR, mk(4'h9, 2'd0, 1'b0, 2'd1, RW, 1'b0, 3'd0));
    add(7'h33, 3'd5, 7'h20, MR, mk(4'hC, 2'd0, 1'b0, 2'd1, RW, 1'b0, 3'd0));
    add(7'h33, 3'd6, 7'h00, MR, mk(4'h4, 2'd0, 1'b0, 2'd1, RW, 1'b0, 3'd0));
    add(7'h33, 3'd7, 7'h00, MR, mk(4'h2, 2'd0, 1'b0, 2'd1, RW, 1'b0, 3'd0));
    for (int f = 0; f < 8; f++)
      add(7'h33, 3'(f), 7'h01, MR, mk(4'h0, 2'd0, 1'b0, 2'd1, RW, 1'b1, 3'(f)));
    // immediate ALU
    add(7'h13, 3'd0, 7'h00, MF3, mk(4'h0, 2'd0, 1'b0, 2'd1, RW | AS, 1'b0, 3'd0));
    add(7'h13, 3'd2, 7'h00, MF3, mk(4'h1, 2'd0, 1'b1, 2'd0, RW | AS, 1'b0, 3'd0));
    add(7'h13, 3'd3, 7'h00, MF3, mk(4'h1, 2'd0, 1'b0, 2'd0, RW | AS, 1'b0, 3'd0));
    add(7'h13, 3'd4, 7'h00, MF3, mk(4'h8, 2'd0, 1'b0, 2'd1, RW | AS, 1'b0, 3'd0));
    add(7'h13, 3'd6, 7'h00, MF3, mk(4'h4, 2'd0, 1'b0, 2'd1, RW | AS, 1'b0, 3'd0));
    add(7'h13, 3'd7, 7'h00, MF3, mk(4'h2, 2'd0, 1'b0, 2'd1, RW | AS, 1'b0, 3'd0));
    add(7'h13, 3'd1, 7'h00, MR,  mk(4'hA, 2'd0, 1'b0, 2'd1, RW | AS, 1'b0, 3'd0));
    add(7'h13, 3'd5, 7'h00, MR,  mk(4'h9, 2'd0, 1'b0, 2'd1, RW | AS, 1'b0, 3'd0));
    add(7'h13, 3'd5, 7'h20, MR,  mk(4'hC, 2'd0, 1'b0, 2'd1, RW | AS, 1'b0, 3'd0));
    // loads
    add(7'h03, 3'd0, 7'h00, MF3, mk(4'h0, 2'd0, 1'b1, 2'd1, RW | MRD | AS, 1'b0, 3'd0));
    add(7'h03, 3'd1, 7'h00, MF3, mk(4'h0, 2'd1, 1'b1, 2'd1, RW | MRD | AS, 1'b0, 3'd0));
    add(7'h03, 3'd2, 7'h00, MF3, mk(4'h0, 2'd2, 1'b1, 2'd1, RW | MRD | AS, 1'b0, 3'd0));
    add(7'h03, 3'd4, 7'h00, MF3, mk(4'h0, 2'd0, 1'b0, 2'd1, RW | MRD | AS, 1'b0, 3'd0));
    add(7'h03, 3'd5, 7'h00, MF3, mk(4'h0, 2'd1, 1'b0, 2'd1, RW | MRD | AS, 1'b0, 3'd0));
    // stores
    for (int f = 0; f < 3; f++)
      add(7'h23, 3'(f), 7'h00, MF3, mk(4'h0, 2'(f), 1'b0, 2'd0, MW | AS, 1'b0, 3'd0));
    // branches: unsigned only for BLTU/BGEU
    add(7'h63, 3'd0, 7'h00, MF3, mk(4'h1, 2'd0, 1'b1, 2'd0, BR, 1'b0, 3'd0));
    add(7'h63, 3'd1, 7'h00, MF3, mk(4'h1, 2'd0, 1'b1, 2'd0, BR, 1'b0, 3'd0));
    add(7'h63, 3'd4, 7'h00, MF3, mk(4'h1, 2'd0, 1'b1, 2'd0, BR, 1'b0, 3'd0));
    add(7'h63, 3'd5, 7'h00, MF3, mk(4'h1, 2'd0, 1'b1, 2'd0, BR, 1'b0, 3'd0));
    add(7'h63, 3'd6, 7'h00, MF3, mk(4'h1, 2'd0, 1'b0, 2'd0, BR, 1'b0, 3'd0));
    add(7'h63, 3'd7, 7'h00, MF3, mk(4'h1, 2'd0, 1'b0, 2'd0, BR, 1'b0, 3'd0));
    // jumps, upper immediates
    add(7'h6F, 3'd0, 7'h00, MOP, mk(4'h0, 2'd0, 1'b0, 2'd2, RW | AS | BR, 1'b0, 3'd0));
    add(7'h67, 3'd0, 7'h00, MF3, mk(4'h0, 2'd0, 1'b0, 2'd2, RW | AS | BR | JR, 1'b0, 3'd0));
    add(7'h37, 3'd0, 7'h00, MOP, mk(4'hD, 2'd0, 1'b0, 2'd1, RW | AS, 1'b0, 3'd0));
    add(7'h17, 3'd0, 7'h00, MOP, mk(4'h0, 2'd0, 1'b0, 2'd1, RW | AS, 1'b0, 3'd0));
  endtask

  function automatic logic [19:0] model(input logic [31:0] w, input bit en_m);
    for (int i = 0; i < t_mask.size(); i++)
      if (((w & t_mask[i]) == t_match[i]) && (en_m || !t_exp[i][3]))
        return t_exp[i];
    return 20'h80000;  // illegal: only the illegal flag set
  endfunction

  function automatic int lat_of(input logic [31:0] w, input bit en_m);
    logic [19:0] e;
    e = model(w, en_m);
    if (!e[3]) return 1;
    return w[14] ? DIV_L : MUL_L;
  endfunction

  // Issue one instruction into an EMPTY stage with out_ready high and follow it
  // to the output. Returns the captured control bundles of both instances.
  task automatic run_one(input logic [31:0] ins, input logic [31:0] pc,
                         output logic [19:0] cap, output logic [19:0] ncap);
    int l, waited;
    l = lat_of(ins, 1'b1);
    in_instr = ins; in_pc = pc; in_valid = 1'b1; out_ready = 1'b1;
    #1 check("accept_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_instr = $urandom;
    check("nm_valid", n_out_valid, 1'b1);
    check("nm_ctrl", n_obs, model(ins, 1'b0));
    ncap = n_obs;
    waited = 1;
    while (!out_valid && waited < 20) begin
      check("md_busy_hi", md_busy, 1'b1);
      check("md_in_ready_lo", in_ready, 1'b0);
      @(posedge clk); #1;
      waited++;
    end
    check("latency", waited, l);
    check("ctrl", obs, model(ins, 1'b1));
    check("out_instr", out_instr, ins);
    check("out_pc", out_pc, pc);
    check("md_busy_lo", md_busy, 1'b0);
    cap = obs;
    @(posedge clk); #1;
    check("drain", out_valid, 1'b0);
  endtask

  logic [19:0] cap, ncap;
  logic [31:0] w, q[$];
  int idx;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    build_table();

    // reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_ctrl", obs, 20'h0);
    check("rst_md_busy", md_busy, 1'b0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_nm_valid", n_out_valid, 1'b0);
    rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;

    // directed instructions
    run_one(I_ADD, 32'h100, cap, ncap);
    check("add_alu", cap[18:15], 4'b0000);
    check("add_wos", cap[11:10], 2'b01);
    check("add_rw", cap[9], 1'b1);
    check("add_illegal", cap[19], 1'b0);
    run_one(I_SLTU, 32'h104, cap, ncap);
    check("sltu_alu", cap[18:15], 4'b0001);
    check("sltu_su", cap[12], 1'b0);
    check("sltu_wos", cap[11:10], 2'b00);
    run_one(I_LBU, 32'h108, cap, ncap);
    check("lbu_mr", cap[8], 1'b1);
    check("lbu_whb", cap[14:13], 2'b00);
    check("lbu_su", cap[12], 1'b0);
    run_one(I_DIV, 32'h10C, cap, ncap);
    check("div_md_op", cap[2:0], 3'b100);
    check("div_md_en", cap[3], 1'b1);
    check("div_nm_illegal", ncap[19], 1'b1);
    run_one(I_ONES, 32'h110, cap, ncap);
    check("ones_illegal", cap[19], 1'b1);
    check("ones_rw_mw_br", {cap[9], cap[7], cap[5]}, 3'b000);

    // randomized instructions: mostly legal templates, some raw words
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(3) == 0) begin
        w = $urandom;
      end else begin
        idx = $urandom_range(t_mask.size() - 1);
        w = ($urandom & ~t_mask[idx]) | t_match[idx];
      end
      run_one(w, $urandom, cap, ncap);
    end

    // back-pressure, then accept with no bubble
    in_instr = I_ADD; in_pc = 32'h200; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_instr = I_SLTU; in_pc = 32'h204;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_valid", out_valid, 1'b1);
      check("bp_instr", out_instr, I_ADD);
      check("bp_pc", out_pc, 32'h200);
      check("bp_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_valid", out_valid, 1'b1);
    check("bp_next_instr", out_instr, I_SLTU);
    check("bp_next_ctrl", obs, model(I_SLTU, 1'b1));
    @(posedge clk); #1;
    check("bp_drain", out_valid, 1'b0);

    // sustained throughput of single-cycle ops
    q.delete();
    for (int k = 0; k < 8; k++) begin
      idx = $urandom_range(t_mask.size() - 1);
      if (t_exp[idx][3]) idx = 0;
      q.push_back(($urandom & ~t_mask[idx]) | t_match[idx]);
    end
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_instr = q[k];
      #1 check("tp_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      check("tp_valid", out_valid, 1'b1);
      check("tp_instr", out_instr, q[k]);
      check("tp_ctrl", obs, model(q[k], 1'b1));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("tp_drain", out_valid, 1'b0);

    // flush during the third MD_WAIT cycle of a DIV; same-cycle accept blocked
    in_instr = I_DIV; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("fl_busy_before", md_busy, 1'b1);
    flush = 1'b1; in_valid = 1'b1; in_instr = I_ADD;
    #1 check("fl_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("fl_out_valid", out_valid, 1'b0);
    check("fl_md_busy", md_busy, 1'b0);
    check("fl_in_ready_after", in_ready, 1'b1);
    @(posedge clk); #1;
    check("fl_no_accept", out_valid, 1'b0);

    // reset while FULL
    in_instr = I_ADD; in_pc = 32'h300; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rf_full", out_valid, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rf_valid", out_valid, 1'b0);
    check("rf_ctrl", obs, 20'h0);
    check("rf_instr", out_instr, 32'h0);
    check("rf_pc", out_pc, 32'h0);
    check("rf_in_ready", in_ready, 1'b0);
    rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;

    // reset during MD_WAIT discards the op
    in_instr = I_DIV; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rm_busy", md_busy, 1'b0);
    repeat (DIV_L) @(posedge clk);
    #1 check("rm_discarded", out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_ctrl_stage.md
# id_ctrl_stage

Registered, parametrised instruction-decode control stage for the pipelined RV32 core. It sits between the IF/ID register and the execute stage and accepts one instruction per cycle over a valid/ready handshake. It decodes the instruction into registered control fields and flags illegal encodings instead of emitting X. When M-extension operations are enabled, it stalls the front end for a programmable multicycle latency.

## Interface
- XLEN, 32, width of the PC path.
- ENABLE_M, 1, decode MUL/DIV/REM (func7 = 0000001 on R opcode). When 0, these encodings are illegal.
- MUL_LATENCY, 2, cycles from accept to out_valid for MUL/MULH/MULHSU/MULHU. Must be ≥ 1.
- DIV_LATENCY, 8, same for DIV/DIVU/REM/REMU. Must be ≥ 1.
- clk  in  1  core clock.
- rst_n  in  1  reset; one clock, reset is synchronous and active-low.
- flush  in  1  kill the held or in-progress instruction.
- in_valid / in_ready  in / out  1 / 1  upstream handshake.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- out_valid / out_ready  out / in  1 / 1  downstream handshake.
- out_instr, out_pc  out  32, XLEN  registered copies.
- alu_ctrl  out  4  ALU op: ADD 0000, SUB 0001, AND 0010, OR 0100, XOR 1000, SRL 1001, SLL 1010, SRA 1100, LUI 1101.
- whb  out  2  access width: 00 byte, 01 half, 10 word.
- su  out  1  1 = signed, 0 = unsigned (loads, SLT vs SLTU, branches).
- wos  out  2  writeback select: 00 compare result, 01 ALU/memory, 10 PC+4.
- reg_write, mem_read, mem_write, alu_src, branch, jalr  out  1 each.
- md_en  out  1  M-extension op.
- md_op  out  3  M-op func3.
- illegal  out  1  undecodable instruction.
- md_busy  out  1  multicycle countdown active.

## Operation
- FSM states: EMPTY, MD_WAIT, FULL.
- in_ready = rst_n & (EMPTY | (FULL & out_ready)) & ~flush.
- Accept (in_valid & in_ready):
  - Load all output registers from the decode.
  - Non-M op → FULL.
  - M op with latency L > 1 → MD_WAIT with counter = L-1.
  - M op with L = 1 → FULL.
- MD_WAIT:
  - out_valid = 0, md_busy = 1, counter decrements each cycle.
  - When the counter reaches 0 → FULL.
- FULL:
  - out_valid = 1; outputs stay stable until out_ready.
  - out_ready without a new accept → EMPTY.
  - out_ready with a new accept → reload, no bubble.
- flush has priority over everything. Next cycle: state EMPTY, counter 0, out_valid 0, md_busy 0. An accept in the same cycle is blocked because in_ready is 0.
- Decode rules:
  - SLT/SLTI → su = 1, wos = 00, alu_ctrl = SUB.
  - SLTU/SLTIU → su = 0, wos = 00, alu_ctrl = SUB.
  - SRAI requires func7 = 0100000. SLLI/SRLI require func7 = 0.
  - BLTU/BGEU → su = 0. Other branches → su = 1.
  - alu_src = 1 for I-ALU, load, store, JAL, JALR, LUI, AUIPC.
  - Loads set mem_read = 1. LBU/LHU set su = 0.
  - JAL/JALR → wos = 10, reg_write = 1, branch = 1. JALR also sets jalr = 1.
- Illegal (unknown opcode, invalid func3/func7, or M op with ENABLE_M = 0):
  - illegal = 1.
  - reg_write, mem_read, mem_write, branch, jalr, md_en all 0.
  - Other fields 0.
  - Passed downstream with out_valid; no multicycle stall.
- Reset values: out_valid 0, all control/data outputs 0, md_busy 0, state EMPTY. in_ready is 0 while rst_n is low.

## Timing
- Non-M op accepted in cycle N → out_valid in N+1.
- M op accepted in cycle N → out_valid in N+L. md_busy is high from N+1 through N+L-1.
- Sustained throughput is 1 instruction/cycle for non-M ops when out_ready is held high.
- Counter width is $clog2(max(MUL_LATENCY, DIV_LATENCY)). Countdown does not wrap; it stops at 0.
- Reset mid-MD_WAIT gives EMPTY on the next edge; the op is discarded.
- out_ready is ignored in EMPTY and MD_WAIT.

## Structure
- Package riscv_ctrl_pkg holds:
  - opcode constants (I1, I2, S, R, B, J, JR, U, UPC);
  - alu_ctrl codes, whb codes, wos codes;
  - a decoded-control struct typedef.
- Sub-module ctrl_decode is purely combinational: instr → control struct plus illegal/md_en. Parameter ENABLE_M is passed through.
- id_ctrl_stage owns the FSM, counter and output registers.

## Test plan
- ADD x3,x1,x2 (0x002081B3), out_ready = 1 → next cycle out_valid = 1, alu_ctrl = 0000, wos = 01, reg_write = 1, illegal = 0.
- SLTU x5,x1,x2 (0x0020B2B3) → alu_ctrl = 0001, su = 0, wos = 00. LBU x4,0(x1) (0x0000C203) → mem_read = 1, whb = 00, su = 0.
- DIV x3,x1,x2 (0x0220C1B3) with DIV_LATENCY = 8, accepted in cycle 0 → md_busy high cycles 1–7, in_ready low, out_valid first in cycle 8 with md_op = 100. Rerun with ENABLE_M = 0 → illegal = 1 in cycle 1, no stall.
- 0xFFFFFFFF → illegal = 1, reg_write = mem_write = branch = 0, out_valid = 1 next cycle.
- Back-pressure: out_ready = 0 for 3 cycles with in_valid high → outputs stable, in_ready = 0. Raising out_ready accepts the next instruction in the same cycle with no bubble.
- flush during DIV MD_WAIT cycle 3 → next cycle out_valid = 0, md_busy = 0, in_ready = 1. rst_n low mid-FULL → out_valid = 0 and all outputs 0 on the next edge.
